// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - preset load handshake bundle for countdown_timer
interface countdown_timer_if #(
    parameter int P_SEC_BIT  = 6,
    parameter int P_MIN_BIT  = 6,
    parameter int P_HOUR_BIT = 5
) ();
    logic                  i_load_valid;
    logic                  o_load_ready;
    logic [P_HOUR_BIT-1:0] i_load_hour;
    logic [P_MIN_BIT-1:0]  i_load_min;
    logic [P_SEC_BIT-1:0]  i_load_sec;
    logic                  o_load_err;

    modport master (
        output i_load_valid, i_load_hour, i_load_min, i_load_sec,
        input  o_load_ready, o_load_err
    );

    modport slave (
        input  i_load_valid, i_load_hour, i_load_min, i_load_sec,
        output o_load_ready, o_load_err
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - hh:mm:ss countdown timer (optional COUNTDOWN_AUTO_RELOAD_EN)
module countdown_timer #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    countdown_timer_if.slave       load,
    input  logic                   i_start,
    input  logic                   i_pause,
    input  logic                   i_clear,
    output logic [P_HOUR_BIT-1:0]  o_hour,
    output logic [P_MIN_BIT-1:0]   o_min,
    output logic [P_SEC_BIT-1:0]   o_sec,
    output logic                   o_running,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);

    state_t                 state_q, state_d;
    logic [P_COUNT_BIT-1:0] presc_q, presc_d;
    logic [P_HOUR_BIT-1:0]  hour_q, hour_d;
    logic [P_MIN_BIT-1:0]   min_q, min_d;
    logic [P_SEC_BIT-1:0]   sec_q, sec_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [P_HOUR_BIT-1:0]  rl_hour_q, rl_hour_d;
    logic [P_MIN_BIT-1:0]   rl_min_q, rl_min_d;
    logic [P_SEC_BIT-1:0]   rl_sec_q, rl_sec_d;
`endif

    logic                   load_ready;
    logic                   load_fire;
    logic                   load_ok;
    logic                   tick;
    logic                   time_zero;
    logic [P_HOUR_BIT-1:0]  hour_dec;
    logic [P_MIN_BIT-1:0]   min_dec;
    logic [P_SEC_BIT-1:0]   sec_dec;
    logic                   dec_zero;

    assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign load_fire  = load.i_load_valid && load_ready;
    assign load_ok    = (load.i_load_hour <= HOUR_MAX) && (load.i_load_min <= MIN_MAX)
                        && (load.i_load_sec <= SEC_MAX);
    // i_freq of 0 or 1 means one tick per clock; >= tolerates i_freq shrinking mid-count
    assign tick       = (i_freq <= P_COUNT_BIT'(1)) || (presc_q >= (i_freq - P_COUNT_BIT'(1)));
    assign time_zero  = (hour_q == '0) && (min_q == '0) && (sec_q == '0);

    // One-second decrement with seconds -> minutes -> hours borrow, saturating at zero
    always_comb begin
        hour_dec = hour_q;
        min_dec  = min_q;
        sec_dec  = sec_q;
        if (sec_q != '0) begin
            sec_dec = sec_q - P_SEC_BIT'(1);
        end else if (min_q != '0) begin
            min_dec = min_q - P_MIN_BIT'(1);
            sec_dec = SEC_MAX;
        end else if (hour_q != '0) begin
            hour_dec = hour_q - P_HOUR_BIT'(1);
            min_dec  = MIN_MAX;
            sec_dec  = SEC_MAX;
        end
    end

    assign dec_zero = (hour_dec == '0) && (min_dec == '0) && (sec_dec == '0);

    // Next-state and datapath: clear beats load, load beats start, a tick's decrement beats pause
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        rl_hour_d = rl_hour_q;
        rl_min_d  = rl_min_q;
        rl_sec_d  = rl_sec_q;
`endif
        if (i_clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            hour_d  = '0;
            min_d   = '0;
            sec_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_fire) begin
                        if (load_ok) begin
                            state_d = ST_IDLE;
                            presc_d = '0;
                            hour_d  = load.i_load_hour;
                            min_d   = load.i_load_min;
                            sec_d   = load.i_load_sec;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            rl_hour_d = load.i_load_hour;
                            rl_min_d  = load.i_load_min;
                            rl_sec_d  = load.i_load_sec;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if ((state_q == ST_IDLE) && i_start) begin
                        if (time_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        hour_d  = hour_dec;
                        min_d   = min_dec;
                        sec_d   = sec_dec;
                        state_d = i_pause ? ST_PAUSE : ST_RUN;
                        if (dec_zero) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if ((rl_hour_q != '0) || (rl_min_q != '0) || (rl_sec_q != '0)) begin
                                hour_d  = rl_hour_q;
                                min_d   = rl_min_q;
                                sec_d   = rl_sec_q;
                                state_d = i_pause ? ST_PAUSE : ST_RUN;
                            end
`endif
                        end
                    end else begin
                        presc_d = presc_q + P_COUNT_BIT'(1);
                        if (i_pause) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_start && !i_pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_hour_q <= '0;
            rl_min_q  <= '0;
            rl_sec_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_hour_q <= rl_hour_d;
            rl_min_q  <= rl_min_d;
            rl_sec_q  <= rl_sec_d;
`endif
        end
    end

    assign load.o_load_ready = load_ready;
    assign load.o_load_err   = err_q;
    assign o_hour            = hour_q;
    assign o_min             = min_q;
    assign o_sec             = sec_q;
    assign o_running         = (state_q == ST_RUN);
    assign o_done            = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] i_freq;
    logic        i_start;
    logic        i_pause;
    logic        i_clear;
    logic [4:0]  o_hour;
    logic [5:0]  o_min;
    logic [5:0]  o_sec;
    logic        o_running;
    logic        o_done;

    int total = 0;
    int bad   = 0;
    int cnt;

    countdown_timer_if #(.P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5)) lif ();

    countdown_timer #(
        .P_COUNT_BIT(30),
        .P_SEC_BIT(6),
        .P_MIN_BIT(6),
        .P_HOUR_BIT(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_freq(i_freq),
        .load(lif.slave),
        .i_start(i_start),
        .i_pause(i_pause),
        .i_clear(i_clear),
        .o_hour(o_hour),
        .o_min(o_min),
        .o_sec(o_sec),
        .o_running(o_running),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        logic [16:0] exp;
        exp = {h[4:0], m[5:0], s[5:0]};
        chk(tag, {15'd0, o_hour, o_min, o_sec}, {15'd0, exp});
    endtask

    task automatic do_load(input int h, input int m, input int s);
        lif.i_load_valid = 1'b1;
        lif.i_load_hour  = h[4:0];
        lif.i_load_min   = m[5:0];
        lif.i_load_sec   = s[5:0];
        step(1);
        lif.i_load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_freq = 30'd4;
        i_start = 1'b0;
        i_pause = 1'b0;
        i_clear = 1'b0;
        lif.i_load_valid = 1'b0;
        lif.i_load_hour = '0;
        lif.i_load_min = '0;
        lif.i_load_sec = '0;
        step(2);
        chk_time("rst_time", 0, 0, 0);
        chk("rst_ready", {31'd0, lif.o_load_ready}, 32'd1);
        chk("rst_running", {31'd0, o_running}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, lif.o_load_err}, 32'd0);
        reset = 1'b0;

        // 62 s at 4 clocks/s: done 248 edges after the start edge
        do_load(0, 1, 2);
        chk_time("load_0102", 0, 1, 2);
        pulse_start();
        chk("run_flag", {31'd0, o_running}, 32'd1);
        chk("run_ready", {31'd0, lif.o_load_ready}, 32'd0);
        step(3);
        chk_time("first_tick_pending", 0, 1, 2);
        step(1);
        chk_time("first_tick", 0, 1, 1);
        cnt = 4;
        while (!o_done && cnt < 400) begin
            step(1);
            cnt++;
        end
        chk("done_latency", cnt, 248);
        chk_time("expired_time", 0, 0, 0);
        chk("expired_ready", {31'd0, lif.o_load_ready}, 32'd1);
        chk("expired_running", {31'd0, o_running}, 32'd0);
        step(1);
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        pulse_start();
        chk("done_ignores_start", {31'd0, o_running}, 32'd0);
        chk_time("done_holds_zero", 0, 0, 0);

        // borrow chain at one tick per clock
        i_freq = 30'd1;
        do_load(1, 0, 0);
        chk("load_exits_done", {31'd0, o_running}, 32'd0);
        pulse_start();
        chk_time("borrow_pre", 1, 0, 0);
        step(1);
        chk_time("borrow_hour", 0, 59, 59);
        pulse_clear();
        chk_time("clear_time", 0, 0, 0);
        chk("clear_running", {31'd0, o_running}, 32'd0);
        do_load(0, 1, 0);
        pulse_start();
        step(1);
        chk_time("borrow_min", 0, 0, 59);
        pulse_clear();

        // out-of-range preset, then load attempts while running
        do_load(0, 0, 7);
        do_load(0, 60, 0);
        chk("err_pulse", {31'd0, lif.o_load_err}, 32'd1);
        chk_time("err_unchanged", 0, 0, 7);
        step(1);
        chk("err_one_cycle", {31'd0, lif.o_load_err}, 32'd0);
        do_load(24, 0, 0);
        chk("err_hour", {31'd0, lif.o_load_err}, 32'd1);
        i_freq = 30'd1000;
        pulse_start();
        lif.i_load_valid = 1'b1;
        lif.i_load_hour = 5'd0;
        lif.i_load_min = 6'd0;
        lif.i_load_sec = 6'd9;
        step(3);
        chk("run_not_ready", {31'd0, lif.o_load_ready}, 32'd0);
        chk_time("run_load_ignored", 0, 0, 7);
        chk("run_still_running", {31'd0, o_running}, 32'd1);
        lif.i_load_valid = 1'b0;
        pulse_clear();

        // zero time start goes straight to DONE
        pulse_start();
        chk("zero_start_done", {31'd0, o_done}, 32'd1);
        chk("zero_start_running", {31'd0, o_running}, 32'd0);

        // load wins over start in the same cycle
        i_freq = 30'd3;
        i_start = 1'b1;
        do_load(0, 0, 5);
        i_start = 1'b0;
        chk("load_beats_start", {31'd0, o_running}, 32'd0);
        chk_time("load_beats_start_time", 0, 0, 5);

        // pause preserves prescaler phase
        pulse_start();
        step(3);
        chk_time("pause_pre", 0, 0, 4);
        step(1);
        i_pause = 1'b1;
        step(1);
        i_pause = 1'b0;
        chk("paused", {31'd0, o_running}, 32'd0);
        step(20);
        chk_time("pause_frozen", 0, 0, 4);
        i_pause = 1'b1;
        i_start = 1'b1;
        step(1);
        i_pause = 1'b0;
        i_start = 1'b0;
        chk("pause_and_start_stays", {31'd0, o_running}, 32'd0);
        pulse_start();
        chk("resumed", {31'd0, o_running}, 32'd1);
        chk_time("resume_hold", 0, 0, 4);
        step(1);
        chk_time("resume_tick", 0, 0, 3);

        // reset mid-run
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_time("midrun_reset_time", 0, 0, 0);
        chk("midrun_reset_running", {31'd0, o_running}, 32'd0);
        chk("midrun_reset_done", {31'd0, o_done}, 32'd0);
        chk("midrun_reset_ready", {31'd0, lif.o_load_ready}, 32'd1);

        // clear mid-pause
        do_load(0, 0, 3);
        pulse_start();
        i_pause = 1'b1;
        step(1);
        i_pause = 1'b0;
        chk("pause_before_clear", {31'd0, o_running}, 32'd0);
        pulse_clear();
        chk_time("pause_clear_time", 0, 0, 0);
        chk("pause_clear_done", {31'd0, o_done}, 32'd0);
        chk("pause_clear_ready", {31'd0, lif.o_load_ready}, 32'd1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // auto reload: 01, 02, 01, 02 with done on each reload
        i_freq = 30'd1;
        do_load(0, 0, 2);
        pulse_start();
        step(1);
        chk_time("ar_1a", 0, 0, 1);
        chk("ar_done_1a", {31'd0, o_done}, 32'd0);
        step(1);
        chk_time("ar_2a", 0, 0, 2);
        chk("ar_done_2a", {31'd0, o_done}, 32'd1);
        chk("ar_running_2a", {31'd0, o_running}, 32'd1);
        step(1);
        chk_time("ar_1b", 0, 0, 1);
        chk("ar_done_1b", {31'd0, o_done}, 32'd0);
        step(1);
        chk_time("ar_2b", 0, 0, 2);
        chk("ar_done_2b", {31'd0, o_done}, 32'd1);
        chk("ar_running_2b", {31'd0, o_running}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
